// File: rtl/riscv_pkg.sv
// Shared RV32 opcode constants, LI sequencer states and output slot bundle.
// LI_EXPAND_EN (optional) enables load-immediate expansion in instr_encoder.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic {
    IDLE,
    LI_ADDI
  } li_state_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] instr;
  } slot_t;

endpackage

// File: rtl/instr_packer.sv
// Combinational RV32 field packer: places fields and immediate per format
// and flags immediates that do not fit the selected format.
module instr_packer
  import riscv_pkg::*;
#(
  parameter int IMM_W = 32
) (
  input  logic [6:0]       opcode,
  input  logic [2:0]       fn3,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [IMM_W-1:0] imm,
  output logic [31:0]      instr,
  output logic             err
);

  logic signed [IMM_W-1:0] imm_s;
  logic [31:0] i32;
  logic fit12, b_rng, j_rng;
  logic is_b, is_j, is_u, is_s, is_r, is_sh, chk_i;

  assign imm_s = imm;
  assign i32   = 32'(imm_s);

  assign fit12 = (imm_s >= -2048) && (imm_s <= 2047);
  assign b_rng = (imm_s >= -4096) && (imm_s <= 4095);
  assign j_rng = (imm_s >= -1048576) && (imm_s <= 1048575);

  assign is_b  = opcode == OP_BRANCH;
  assign is_j  = opcode == OP_JAL;
  assign is_u  = (opcode == OP_LUI) || (opcode == OP_AUIPC);
  assign is_s  = opcode == OP_STORE;
  assign is_r  = opcode == OP_REG;
  assign is_sh = (opcode == OP_IMM) && (fn3[1:0] == 2'b01);
  assign chk_i = (opcode == OP_IMM) || (opcode == OP_JALR) ||
                 (opcode == OP_LOAD);

  always_comb begin
    instr = {i32[11:0], rs1, fn3, rd, opcode};
    err   = chk_i && !fit12;
    unique case (1'b1)
      is_b: begin
        instr = {i32[12], i32[10:5], rs2, rs1, fn3,
                 i32[4:1], i32[11], opcode};
        err   = i32[0] || !b_rng;
      end
      is_j: begin
        instr = {i32[20], i32[10:1], i32[11], i32[19:12],
                 rd, opcode};
        err   = i32[0] || !j_rng;
      end
      is_u: begin
        instr = {i32[31:12], rd, opcode};
        err   = i32[11:0] != 12'd0;
      end
      is_s: begin
        instr = {i32[11:5], rs2, rs1, fn3, i32[4:0], opcode};
        err   = !fit12;
      end
      is_r: begin
        instr = {i32[11:5], rs2, rs1, fn3, rd, opcode};
        err   = 1'b0;
      end
      // shift amount is 5 bits; imm[10] selects arithmetic right shift
      is_sh: begin
        instr = {(i32[10] ? 7'b0100000 : 7'b0000000), i32[4:0],
                 rs1, fn3, rd, opcode};
        err   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32 instruction encoder with a one-entry registered output slot.
// Define LI_EXPAND_EN to enable LUI/ADDI load-immediate expansion.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int IMM_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       fn3,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [IMM_W-1:0] imm,
  input  logic             in_li,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic             li_busy
);

  slot_t slot_q, slot_d;
  logic [31:0] p_instr;
  logic p_err;
  logic slot_free, accept;
  logic ld_en, ld_err;
  logic [31:0] ld_instr;

  instr_packer #(.IMM_W(IMM_W)) u_packer (
    .opcode (opcode),
    .fn3    (fn3),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .imm    (imm),
    .instr  (p_instr),
    .err    (p_err)
  );

  assign slot_free = !slot_q.valid || out_ready;
  assign accept    = in_valid && in_ready;

`ifdef LI_EXPAND_EN
  li_state_e state_q, state_d;
  logic [31:0] addi_q, addi_d;
  logic signed [IMM_W-1:0] imm_s;
  logic [31:0] i32, li_sum, lui_w, addi0_w, addi1_w, first_w;
  logic [19:0] hi;
  logic [11:0] lo;
  logic li_two;

  assign imm_s = imm;
  assign i32   = 32'(imm_s);
  // +0x800 rounds hi so the sign-extended ADDI low part lands exactly
  assign li_sum  = i32 + 32'h0000_0800;
  assign hi      = li_sum[31:12];
  assign lo      = i32[11:0];
  assign lui_w   = {hi, rd, OP_LUI};
  assign addi0_w = {lo, 5'd0, 3'b000, rd, OP_IMM};
  assign addi1_w = {lo, rd, 3'b000, rd, OP_IMM};
  assign first_w = (hi == 20'd0) ? addi0_w : lui_w;
  assign li_two  = (hi != 20'd0) && (lo != 12'd0);

  assign in_ready = (state_q == IDLE) && slot_free;
  assign li_busy  = state_q == LI_ADDI;

  always_comb begin
    state_d  = state_q;
    addi_d   = addi_q;
    ld_en    = 1'b0;
    ld_err   = 1'b0;
    ld_instr = p_instr;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ld_en    = 1'b1;
          ld_instr = in_li ? first_w : p_instr;
          ld_err   = in_li ? 1'b0 : p_err;
          if (in_li && li_two) begin
            state_d = LI_ADDI;
            addi_d  = addi1_w;
          end
        end
      end
      LI_ADDI: begin
        if (slot_free) begin
          ld_en    = 1'b1;
          ld_instr = addi_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addi_q  <= '0;
    end else begin
      state_q <= state_d;
      addi_q  <= addi_d;
    end
  end
`else
  logic unused_li;

  assign unused_li = in_li;
  assign in_ready  = slot_free;
  assign li_busy   = 1'b0;
  assign ld_en     = accept;
  assign ld_instr  = p_instr;
  assign ld_err    = p_err;
`endif

  always_comb begin
    slot_d = slot_q;
    if (ld_en) begin
      slot_d.valid = 1'b1;
      slot_d.err   = ld_err;
      slot_d.instr = ld_instr;
    end else if (slot_q.valid && out_ready) begin
      slot_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign out_valid = slot_q.valid;
  assign out_instr = slot_q.instr;
  assign out_err   = slot_q.err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder; LI cases follow LI_EXPAND_EN.
// Expected words are hand-assembled RV32 encodings.
module tb_instr_encoder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  fn3 = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] imm = '0;
  logic        in_li = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic        li_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.IMM_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .fn3       (fn3),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .in_li     (in_li),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .li_busy   (li_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd_v, input logic [4:0] rs1_v,
                       input logic [4:0] rs2_v, input logic [31:0] im,
                       input logic li);
    int n;
    n = 0;
    @(negedge clk);
    opcode   = op;
    fn3      = f3;
    rd       = rd_v;
    rs1      = rs1_v;
    rs2      = rs2_v;
    imm      = im;
    in_li    = li;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_li    = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] w,
                            input logic e);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_instr"}, out_instr, w);
    chk({tag, "_err"}, out_err, e);
  endtask

  initial begin
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_err", out_err, 0);
    chk("rst_busy", li_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(OP_IMM, 3'b000, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
    expect_out("addi_m1", 32'hFFF0_0293, 1'b0);
    issue(OP_BRANCH, 3'b000, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    expect_out("beq8", 32'h0020_8463, 1'b0);
    issue(OP_BRANCH, 3'b000, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
    expect_out("beq3", 32'h0020_8163, 1'b1);
    issue(OP_JAL, 3'b000, 5'd1, 5'd0, 5'd0, 32'h800, 1'b0);
    expect_out("jal800", 32'h0010_00EF, 1'b0);
    issue(OP_JAL, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0010_0000, 1'b0);
    expect_out("jal_rng", 32'h8000_006F, 1'b1);
    issue(OP_LUI, 3'b000, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
    expect_out("lui", 32'h1234_52B7, 1'b0);
    issue(OP_LUI, 3'b000, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 1'b0);
    expect_out("lui_low", 32'h1234_52B7, 1'b1);
    issue(OP_STORE, 3'b010, 5'd0, 5'd2, 5'd3, 32'h7FC, 1'b0);
    expect_out("sw", 32'h7E31_2E23, 1'b0);
    issue(OP_IMM, 3'b000, 5'd1, 5'd0, 5'd0, 32'h800, 1'b0);
    expect_out("addi_rng", 32'h8000_0093, 1'b1);
    issue(OP_IMM, 3'b101, 5'd1, 5'd2, 5'd0, 32'h403, 1'b0);
    expect_out("srai", 32'h4031_5093, 1'b0);
    issue(OP_REG, 3'b000, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
    expect_out("add", 32'h0020_81B3, 1'b0);
    issue(OP_REG, 3'b000, 5'd3, 5'd1, 5'd2, 32'h400, 1'b0);
    expect_out("sub", 32'h4020_81B3, 1'b0);

    @(negedge clk);
    out_ready = 1'b0;
    issue(OP_STORE, 3'b010, 5'd0, 5'd2, 5'd3, 32'h7FC, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_instr", out_instr, 32'h7E31_2E23);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain", out_valid, 0);

`ifdef LI_EXPAND_EN
    issue(OP_IMM, 3'b000, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, 1'b1);
    expect_out("li_lui", 32'h1234_6537, 1'b0);
    chk("li_busy1", li_busy, 1);
    chk("li_rdy0", in_ready, 0);
    expect_out("li_addi", 32'hFFF5_0513, 1'b0);
    chk("li_busy0", li_busy, 0);
    issue(OP_IMM, 3'b000, 5'd10, 5'd0, 5'd0, 32'h5, 1'b1);
    expect_out("li_small", 32'h0050_0513, 1'b0);
    chk("li_small_busy", li_busy, 0);

    out_ready = 1'b0;
    issue(OP_IMM, 3'b000, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, 1'b1);
    @(negedge clk);
    chk("lirst_lui", out_instr, 32'h1234_6537);
    chk("lirst_busy", li_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("lirst_valid", out_valid, 0);
    chk("lirst_instr", out_instr, 32'h0);
    chk("lirst_busy0", li_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lirst_quiet", out_valid, 0);
    end
`else
    issue(OP_IMM, 3'b000, 5'd10, 5'd0, 5'd0, 32'h5, 1'b1);
    expect_out("noli_small", 32'h0050_0513, 1'b0);
    chk("noli_busy", li_busy, 0);
    issue(OP_IMM, 3'b000, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, 1'b1);
    expect_out("noli_big", 32'hFFF0_0513, 1'b1);
    chk("noli_busy2", li_busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter: IMM_W, 32, width of the immediate/constant input.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: in_valid input 1, in_ready output 1  request handshake.
REQ-005 SHALL have ports: opcode input 7, fn3 input 3, rd input 5, rs1 input 5, rs2 input 5  instruction fields.
REQ-006 SHALL have port: imm  input  IMM_W  byte-offset/immediate value, two's complement.
REQ-007 SHALL have port: in_li  input  1  request is load-immediate pseudo-op (rd, imm used).
REQ-008 SHALL have ports: out_valid output 1, out_ready input 1, out_instr output 32, out_err output 1.
REQ-009 SHALL have port: li_busy  output  1  pending second half of a load-immediate.

Function
REQ-010 SHALL hold one registered output slot; a request is accepted when in_valid && in_ready; out_valid rises the cycle after acceptance (latency 1).
REQ-011 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready); accept and drain in the same cycle are allowed.
REQ-012 SHALL hold out_instr/out_err stable while out_valid && !out_ready.
REQ-013 SHALL place opcode[6:0], rd[11:7], fn3[14:12], rs1[19:15], rs2[24:20] per the RISC-V base formats for the selected type.
REQ-014 SHALL encode B (1100011): [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
REQ-015 SHALL encode J (1101111): [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
REQ-016 SHALL encode U (0110111, 0010111): [31:12]=imm[31:12].
REQ-017 SHALL encode S (0100011): [31:25]=imm[11:5], [11:7]=imm[4:0].
REQ-018 SHALL encode 0010011 with fn3 001/101 as [24:20]=imm[4:0], [31:25]=imm[10]?0100000:0000000; other fn3, JALR, loads and all remaining opcodes as [31:20]=imm[11:0].
REQ-019 SHALL encode R (0110011) with [31:25]=imm[11:5].
REQ-020 SHALL set out_err when: B/J imm[0]!=0; B imm outside -4096..4094; J outside -1048576..1048574; I/S imm not sign-extension of imm[11:0]; U imm[11:0]!=0; shift imm[4:0] excepted from I range check. The instruction SHALL still be emitted with truncated fields.
REQ-021 SHALL, for in_li, compute hi=(imm+0x800)>>12 mod 2^20, lo=imm[11:0]; hi==0 -> single ADDI rd,x0,lo; lo==0 -> single LUI rd,hi; else LUI rd,hi then ADDI rd,rd,lo.
REQ-022 SHALL use states IDLE and LI_ADDI; IDLE->LI_ADDI when a two-word LI is accepted; LI_ADDI->IDLE when the ADDI is loaded into the output slot (slot empty or draining); li_busy=(state==LI_ADDI).
REQ-023 SHALL never flag out_err for load-immediate words.

Reset
REQ-024 SHALL on rst_n low immediately clear out_valid, out_err, out_instr (0x00000000), li_busy; state -> IDLE.
REQ-025 SHALL discard a pending LI ADDI on reset mid-sequence; no word emitted after release until a new request.

Configuration
REQ-026 SHALL compile load-immediate expansion only with LI_EXPAND_EN defined; with it, REQ-021/022 apply.
REQ-027 SHALL without LI_EXPAND_EN omit the state machine, treat in_li as ignored (normal encode), tie li_busy to 0.

Structure
REQ-028 SHALL place opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG) and the state enum in shared package riscv_pkg.
REQ-029 SHALL implement the combinational field packer as sub-module instr_packer (fields in -> {instr, err}).

Verification
REQ-030 SHALL test opcode 0010011 fn3 0 rd 5 rs1 0 imm 0xFFFFFFFF -> out_instr 0xFFF00293, err 0.
REQ-031 SHALL test BEQ rs1 1 rs2 2 imm 8 -> 0x00208463; same with imm 3 -> out_err 1.
REQ-032 SHALL test JAL rd 1 imm 0x800 -> 0x001000EF.
REQ-033 SHALL test LI rd 10 imm 0x12345FFF -> 0x12346537 then 0xFFF50513, in_ready 0 between; imm 0x00000005 -> single 0x00500513.
REQ-034 SHALL test out_ready low 3 cycles -> out_instr stable, in_ready 0; rst_n low during LI_ADDI -> no ADDI emitted.
